// File: rtl/linked_list_fifo_v2.sv
// linked_list_fifo_v2
// Several logical FIFOs share one data RAM. Each queue owns a sentinel tail
// node, so a queue is empty when beg == end. Unused nodes sit on a singly
// linked free list whose head is r_free_head; the value DEPTH (MSB set) is
// the null link, so the free list is exhausted when the head's MSB is set.
// After reset, the free list is rebuilt in hardware, one link per cycle.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_push/i_push_fifo/i_d   push request, target queue, data
//   o_push_ready             push accepted when i_push && o_push_ready
//   i_pop/i_pop_fifo         pop request, source queue
//   o_pop_ready              source queue non-empty and init complete
//   o_q/o_q_valid/o_q_fifo   popped word, one cycle after the pop
//   o_empty_vec, o_count     per-queue empty flags and occupancies
//   o_free_count, o_full     unallocated entries, free list exhausted
//   o_almost_full            o_free_count < AF_THRESH
//   o_init_done              free-list build complete
//   o_overflow/o_underflow   sticky rejected push/pop after init
module linked_list_fifo_v2 #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int AF_THRESH  = 2,
  parameter int LOG2_FIFOS = $clog2(FIFOS),
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_push,
  input  logic [LOG2_FIFOS-1:0]            i_push_fifo,
  input  logic [WIDTH-1:0]                 i_d,
  output logic                             o_push_ready,
  input  logic                             i_pop,
  input  logic [LOG2_FIFOS-1:0]            i_pop_fifo,
  output logic                             o_pop_ready,
  output logic [WIDTH-1:0]                 o_q,
  output logic                             o_q_valid,
  output logic [LOG2_FIFOS-1:0]            o_q_fifo,
  output logic [FIFOS-1:0]                 o_empty_vec,
  output logic [FIFOS*(LOG2_DEPTH+1)-1:0]  o_count,
  output logic [LOG2_DEPTH:0]              o_free_count,
  output logic                             o_full,
  output logic                             o_almost_full,
  output logic                             o_init_done,
  output logic                             o_overflow,
  output logic                             o_underflow
);

  localparam int LD = LOG2_DEPTH;
  localparam int CW = LOG2_DEPTH + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [LD-1:0]     r_walk;
  logic [WIDTH-1:0]  r_ram  [DEPTH];
  logic [CW-1:0]     r_link [DEPTH];
  logic [LD-1:0]     r_beg  [FIFOS];
  logic [LD-1:0]     r_end  [FIFOS];
  logic [CW-1:0]     r_cnt  [FIFOS];
  logic [CW-1:0]     r_free_head;
  logic [CW-1:0]     r_free_count;
  logic              r_init_done;
  logic              r_overflow;
  logic              r_underflow;
  logic [WIDTH-1:0]  r_q;
  logic              r_q_valid;
  logic [LOG2_FIFOS-1:0] r_q_fifo;

  logic              w_full;
  logic [FIFOS-1:0]  w_empty;
  logic              w_pop_acc;
  logic              w_push_acc;
  logic              w_same_q;
  logic [LD-1:0]     w_pop_node;

  always_comb begin
    w_empty = '0;
    o_count = '0;
    for (int i = 0; i < FIFOS; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      o_count[i*CW +: CW] = r_cnt[i];
    end
  end

  assign w_full       = r_free_head[LD];
  assign o_pop_ready  = r_init_done && !w_empty[i_pop_fifo];
  assign w_pop_acc    = i_pop && o_pop_ready;
  // A same-cycle pop frees a node that the push can take over, so a push
  // is still accepted while the free list is exhausted.
  assign o_push_ready = r_init_done && (!w_full || w_pop_acc);
  assign w_push_acc   = i_push && o_push_ready;
  assign w_same_q     = (i_push_fifo == i_pop_fifo);
  assign w_pop_node   = r_beg[i_pop_fifo];

  // Data and link storage: no reset, the INIT walk rebuilds every link.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_link[r_walk] <= {1'b0, r_walk} + 1'b1;
    end else begin
      if (w_push_acc) begin
        r_ram[r_end[i_push_fifo]]  <= i_d;
        r_link[r_end[i_push_fifo]] <= w_pop_acc ? {1'b0, w_pop_node} : r_free_head;
      end else if (w_pop_acc) begin
        r_link[w_pop_node] <= r_free_head;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_INIT;
      r_walk       <= '0;
      r_init_done  <= 1'b0;
      r_free_head  <= CW'(FIFOS);
      r_free_count <= CW'(DEPTH - FIFOS);
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_q          <= '0;
      r_q_valid    <= 1'b0;
      r_q_fifo     <= '0;
      for (int i = 0; i < FIFOS; i++) begin
        r_beg[i] <= LD'(i);
        r_end[i] <= LD'(i);
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          r_walk <= r_walk + 1'b1;
          if (r_walk == LD'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_push && !o_push_ready) r_overflow  <= 1'b1;
          if (i_pop  && !o_pop_ready)  r_underflow <= 1'b1;

          r_q_valid <= w_pop_acc;
          if (w_pop_acc) begin
            r_q      <= r_ram[w_pop_node];
            r_q_fifo <= i_pop_fifo;
            r_beg[i_pop_fifo] <= r_link[w_pop_node][LD-1:0];
          end

          if (w_push_acc)
            r_end[i_push_fifo] <= w_pop_acc ? w_pop_node : r_free_head[LD-1:0];

          if (w_push_acc && !w_pop_acc) begin
            r_free_head  <= r_link[r_free_head[LD-1:0]];
            r_free_count <= r_free_count - 1'b1;
          end else if (w_pop_acc && !w_push_acc) begin
            r_free_head  <= {1'b0, w_pop_node};
            r_free_count <= r_free_count + 1'b1;
          end

          if (w_push_acc && !(w_pop_acc && w_same_q))
            r_cnt[i_push_fifo] <= r_cnt[i_push_fifo] + 1'b1;
          if (w_pop_acc && !(w_push_acc && w_same_q))
            r_cnt[i_pop_fifo] <= r_cnt[i_pop_fifo] - 1'b1;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign o_q           = r_q;
  assign o_q_valid     = r_q_valid;
  assign o_q_fifo      = r_q_fifo;
  assign o_empty_vec   = w_empty;
  assign o_free_count  = r_free_count;
  assign o_full        = w_full;
  assign o_almost_full = (r_free_count < CW'(AF_THRESH));
  assign o_init_done   = r_init_done;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule
